// File: rtl/multicycle_control.sv
// Multicycle LEGv8 control sequencer: decodes the opcode once per instruction
// and steps the datapath through fetch/decode/execute/memory/write-back.
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        reg2loc,
    output logic        alu_src,
    output logic [3:0]  alu_control,
    output logic        instr_done,
    output logic        illegal
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_WB_R     = 4'd3;
    localparam logic [3:0] S_ADDR     = 4'd4;
    localparam logic [3:0] S_LOAD     = 4'd5;
    localparam logic [3:0] S_WB_L     = 4'd6;
    localparam logic [3:0] S_STORE    = 4'd7;
    localparam logic [3:0] S_CBZ_EVAL = 4'd8;
    localparam logic [3:0] S_ILLEGAL  = 4'd9;

    localparam logic [2:0] C_NONE = 3'd0;
    localparam logic [2:0] C_ADD  = 3'd1;
    localparam logic [2:0] C_SUB  = 3'd2;
    localparam logic [2:0] C_AND  = 3'd3;
    localparam logic [2:0] C_ORR  = 3'd4;
    localparam logic [2:0] C_LDUR = 3'd5;
    localparam logic [2:0] C_STUR = 3'd6;
    localparam logic [2:0] C_CBZ  = 3'd7;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    logic [3:0] state;
    logic [3:0] state_next;
    logic [2:0] cls;
    logic [2:0] dec_cls;
    logic [3:0] r_alu;
    logic       is_rtype;

    always_comb begin
        dec_cls = C_NONE;
        casez (opcode)
            11'b10001011000: dec_cls = C_ADD;
            11'b11001011000: dec_cls = C_SUB;
            11'b10001010000: dec_cls = C_AND;
            11'b10101010000: dec_cls = C_ORR;
            11'b11111000010: dec_cls = C_LDUR;
            11'b11111000000: dec_cls = C_STUR;
            11'b10110100???: dec_cls = C_CBZ;
            default:         dec_cls = C_NONE;
        endcase
    end

    assign is_rtype = (dec_cls == C_ADD) || (dec_cls == C_SUB) ||
                      (dec_cls == C_AND) || (dec_cls == C_ORR);

    // ALU operation for the captured R-class, held across EXEC_R and WB_R
    always_comb begin
        r_alu = ALU_ADD;
        case (cls)
            C_SUB:   r_alu = ALU_SUB;
            C_AND:   r_alu = ALU_AND;
            C_ORR:   r_alu = ALU_ORR;
            default: r_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                if (is_rtype)
                    state_next = S_EXEC_R;
                else if (dec_cls == C_LDUR || dec_cls == C_STUR)
                    state_next = S_ADDR;
                else if (dec_cls == C_CBZ)
                    state_next = S_CBZ_EVAL;
                else
                    state_next = S_ILLEGAL;
            end
            S_EXEC_R:   state_next = S_WB_R;
            S_WB_R:     state_next = S_FETCH;
            S_ADDR: begin
                if (cls == C_LDUR)
                    state_next = S_LOAD;
                else if (cls == C_STUR)
                    state_next = S_STORE;
                else
                    state_next = S_ILLEGAL;
            end
            S_LOAD: begin
                if (mem_ready) state_next = S_WB_L;
            end
            S_WB_L:     state_next = S_FETCH;
            S_STORE: begin
                if (mem_ready) state_next = S_FETCH;
            end
            S_CBZ_EVAL: state_next = S_FETCH;
            S_ILLEGAL:  state_next = S_ILLEGAL;
            default:    state_next = S_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_FETCH;
            cls   <= C_NONE;
        end else begin
            state <= state_next;
            if (state == S_DECODE)
                cls <= dec_cls;
        end
    end

    // Strobes are decoded from state; a low reset overrides everything
    always_comb begin
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        ir_write    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        reg2loc     = 1'b0;
        alu_src     = 1'b0;
        alu_control = ALU_ADD;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_DECODE: begin
                reg2loc = (dec_cls == C_STUR) || (dec_cls == C_CBZ);
            end
            S_EXEC_R: begin
                alu_control = r_alu;
            end
            S_WB_R: begin
                reg_write   = 1'b1;
                alu_control = r_alu;
                instr_done  = 1'b1;
            end
            S_ADDR: begin
                alu_src = 1'b1;
            end
            S_LOAD: begin
                mem_read = 1'b1;
                alu_src  = 1'b1;
            end
            S_WB_L: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_STORE: begin
                mem_write  = 1'b1;
                alu_src    = 1'b1;
                reg2loc    = 1'b1;
                instr_done = mem_ready;
            end
            S_CBZ_EVAL: begin
                reg2loc     = 1'b1;
                alu_control = ALU_PASSB;
                instr_done  = 1'b1;
                pc_write    = zero;
                pc_src      = zero;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
        if (!reset) begin
            pc_write    = 1'b0;
            pc_src      = 1'b0;
            ir_write    = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            reg_write   = 1'b0;
            mem_to_reg  = 1'b0;
            reg2loc     = 1'b0;
            alu_src     = 1'b0;
            alu_control = 4'b0000;
            instr_done  = 1'b0;
            illegal     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control vectors.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, pc_src, ir_write, mem_read, mem_write;
    logic        reg_write, mem_to_reg, reg2loc, alu_src;
    logic [3:0]  alu_control;
    logic        instr_done, illegal;
    logic [14:0] outs;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .reg2loc(reg2loc),
        .alu_src(alu_src), .alu_control(alu_control),
        .instr_done(instr_done), .illegal(illegal)
    );

    assign outs = {pc_write, pc_src, ir_write, mem_read, mem_write,
                   reg_write, mem_to_reg, reg2loc, alu_src, alu_control,
                   instr_done, illegal};

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ1 = 11'b10110100101;
    localparam logic [10:0] OP_CBZ0 = 11'b10110100000;
    localparam logic [10:0] OP_BAD  = 11'b11111111111;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] v(
        input logic pcw, pcs, irw, mr, mw, rw, m2r, r2l, as,
        input logic [3:0] alu, input logic done, ill);
        return {pcw, pcs, irw, mr, mw, rw, m2r, r2l, as, alu, done, ill};
    endfunction

    task automatic cyc(input string tag, input logic rst, mr, z,
                       input logic [10:0] op, input logic [14:0] exp,
                       input logic [14:0] mask);
        @(negedge clk);
        reset     = rst;
        mem_ready = mr;
        zero      = z;
        opcode    = op;
        #1;
        if (instr_done === 1'b1) done_cnt++;
        check(tag, {1'b0, outs & mask}, {1'b0, exp & mask});
    endtask

    logic [14:0] all_m, ill_m;
    logic [14:0] zr, f_rdy, f_stl, dec0, dec1, adr, ld, wbl;
    logic [14:0] st_stl, st_rdy, cbz1, cbz0, ill;
    logic [10:0] r_ops [3];
    logic [3:0]  r_alu [3];

    initial begin
        all_m  = 15'h7FFF;
        ill_m  = 15'h7FC3;
        zr     = v(0,0,0,0,0,0,0,0,0,4'b0000,0,0);
        f_rdy  = v(1,0,1,1,0,0,0,0,0,4'b0010,0,0);
        f_stl  = v(0,0,0,1,0,0,0,0,0,4'b0010,0,0);
        dec0   = v(0,0,0,0,0,0,0,0,0,4'b0010,0,0);
        dec1   = v(0,0,0,0,0,0,0,1,0,4'b0010,0,0);
        adr    = v(0,0,0,0,0,0,0,0,1,4'b0010,0,0);
        ld     = v(0,0,0,1,0,0,0,0,1,4'b0010,0,0);
        wbl    = v(0,0,0,0,0,1,1,0,0,4'b0010,1,0);
        st_stl = v(0,0,0,0,1,0,0,1,1,4'b0010,0,0);
        st_rdy = v(0,0,0,0,1,0,0,1,1,4'b0010,1,0);
        cbz1   = v(1,1,0,0,0,0,0,1,0,4'b0111,1,0);
        cbz0   = v(0,0,0,0,0,0,0,1,0,4'b0111,1,0);
        ill    = v(0,0,0,0,0,0,0,0,0,4'b0010,0,1);
        r_ops  = '{OP_SUB, OP_AND, OP_ORR};
        r_alu  = '{4'b0110, 4'b0000, 4'b0001};

        reset = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = OP_BAD;
        cyc("rst", 0, 1, 0, OP_BAD, zr, all_m);

        // ADD; opcode and mem_ready are junk outside the states sampling them
        cyc("add_f",  1, 1, 0, OP_BAD, f_rdy, all_m);
        cyc("add_d",  1, 1, 0, OP_ADD, dec0, all_m);
        cyc("add_x",  1, 0, 1, OP_BAD,
            v(0,0,0,0,0,0,0,0,0,4'b0010,0,0), all_m);
        cyc("add_wb", 1, 0, 1, OP_BAD,
            v(0,0,0,0,0,1,0,0,0,4'b0010,1,0), all_m);

        for (int i = 0; i < 3; i++) begin
            cyc("r_f",  1, 1, 0, OP_BAD, f_rdy, all_m);
            cyc("r_d",  1, 1, 0, r_ops[i], dec0, all_m);
            cyc("r_x",  1, 1, 0, OP_BAD,
                v(0,0,0,0,0,0,0,0,0,r_alu[i],0,0), all_m);
            cyc("r_wb", 1, 1, 0, OP_BAD,
                v(0,0,0,0,0,1,0,0,0,r_alu[i],1,0), all_m);
        end
        check("done_r", 16'(done_cnt), 16'd4);

        cyc("ld_fs0", 1, 0, 0, OP_BAD, f_stl, all_m);
        cyc("ld_fs1", 1, 0, 0, OP_BAD, f_stl, all_m);
        cyc("ld_f",   1, 1, 0, OP_BAD, f_rdy, all_m);
        cyc("ld_d",   1, 1, 0, OP_LDUR, dec0, all_m);
        cyc("ld_a",   1, 0, 0, OP_BAD, adr, all_m);
        for (int i = 0; i < 3; i++)
            cyc("ld_ls", 1, 0, 0, OP_BAD, ld, all_m);
        cyc("ld_l",   1, 1, 0, OP_BAD, ld, all_m);
        cyc("ld_wb",  1, 0, 0, OP_BAD, wbl, all_m);
        check("done_ld", 16'(done_cnt), 16'd5);

        cyc("st_f",  1, 1, 0, OP_BAD, f_rdy, all_m);
        cyc("st_d",  1, 1, 0, OP_STUR, dec1, all_m);
        cyc("st_a",  1, 1, 0, OP_BAD, adr, all_m);
        cyc("st_ss", 1, 0, 0, OP_BAD, st_stl, all_m);
        cyc("st_s",  1, 1, 0, OP_BAD, st_rdy, all_m);

        cyc("cb1_f", 1, 1, 0, OP_BAD, f_rdy, all_m);
        cyc("cb1_d", 1, 1, 0, OP_CBZ1, dec1, all_m);
        cyc("cb1_e", 1, 1, 1, OP_BAD, cbz1, all_m);
        cyc("cb0_f", 1, 1, 1, OP_BAD, f_rdy, all_m);
        cyc("cb0_d", 1, 1, 1, OP_CBZ0, dec1, all_m);
        cyc("cb0_e", 1, 1, 0, OP_BAD, cbz0, all_m);
        check("done_cbz", 16'(done_cnt), 16'd8);

        cyc("il_f", 1, 1, 0, OP_BAD, f_rdy, all_m);
        cyc("il_d", 1, 1, 0, OP_BAD, dec0, all_m);
        for (int i = 0; i < 20; i++)
            cyc("il_hold", 1, i[0], i[1], OP_ADD, ill, ill_m);
        check("done_il", 16'(done_cnt), 16'd8);
        cyc("il_rst", 0, 1, 1, OP_BAD, zr, all_m);
        cyc("il_out", 1, 1, 0, OP_BAD, f_rdy, all_m);

        // Abort a load mid-stall; the aborted load must never write back
        cyc("ab_d",   1, 1, 0, OP_LDUR, dec0, all_m);
        cyc("ab_a",   1, 1, 0, OP_BAD, adr, all_m);
        cyc("ab_ls",  1, 0, 0, OP_BAD, ld, all_m);
        cyc("ab_rst", 0, 0, 0, OP_BAD, zr, all_m);
        cyc("ab_f",   1, 1, 0, OP_BAD, f_rdy, all_m);
        cyc("ab_d2",  1, 1, 0, OP_ADD, dec0, all_m);
        cyc("ab_x",   1, 1, 0, OP_BAD,
            v(0,0,0,0,0,0,0,0,0,4'b0010,0,0), all_m);
        cyc("ab_wb",  1, 1, 0, OP_BAD,
            v(0,0,0,0,0,1,0,0,0,4'b0010,1,0), all_m);
        check("done_all", 16'(done_cnt), 16'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
